// File: rtl/ue14500_pkg.sv
// Shared definitions for the ue14500 sequencer: opcode encodings and
// instruction-word field positions.
package ue14500_pkg;

    typedef enum logic [3:0] {
        OP_NOP0 = 4'b0000,
        OP_LD   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_ONE  = 4'b0100,
        OP_NAND = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_STO  = 4'b1000,
        OP_STOC = 4'b1001,
        OP_IEN  = 4'b1010,
        OP_OEN  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RTN  = 4'b1101,
        OP_SKZ  = 4'b1110,
        OP_NOPF = 4'b1111
    } opcode_t;

    // Instruction word layout: {opcode[3:0], operand[PC_W-1:0]}
    localparam int OPC_W   = 4;
    localparam int OPR_LSB = 0;

    // Opcode field sits directly above the operand field.
    function automatic int opc_lsb(input int pc_w);
        return OPR_LSB + pc_w;
    endfunction

endpackage

// File: rtl/ue14500_ret_stack.sv
// Return-address LIFO. Only the pointer is reset; entry contents are
// meaningless until pushed. Pushes when full and pops when empty are
// dropped here; the caller flags the error.
module ue14500_ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_SP = (AW+1)'(DEPTH);

    logic [AW:0]   sp;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = sp[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign top     = mem[top_idx];
    assign full    = (sp == FULL_SP);
    assign empty   = (sp == '0);

    // Stack pointer: count entries, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (AW+1)'(1);
        end
    end

    // Entry storage: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/ue14500_sequencer.sv
// Instruction sequencer for the ue14500 ICU: fetches from an async ROM,
// registers opcode/operand for the ICU and acts on the ICU's JMP/RTN/F
// decode of the instruction currently on ins_out.
//
// run is a plain level enable, not a handshake: while run=1 one word is
// issued per edge, while run=0 NOP0 is issued and pc holds. Flag actions
// (jump, return, halt) happen at the edge regardless of run.
module ue14500_sequencer
    import ue14500_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int DEPTH     = 4,
    parameter bit HALT_ON_F = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic [PC_W-1:0]       mem_addr,
    input  logic [OPC_W+PC_W-1:0] mem_data,
    output logic [OPC_W-1:0]      ins_out,
    output logic [PC_W-1:0]       io_sel,
    input  logic                  jmp_flag,
    input  logic                  rtn_flag,
    input  logic                  flag_f,
    output logic                  halted,
    output logic                  stk_err
);
    localparam int OPC_LSB = opc_lsb(PC_W);

    logic [PC_W-1:0]  pc, pc_d;
    logic [PC_W-1:0]  iss_pc, iss_pc_d;
    logic [PC_W-1:0]  io_sel_d;
    logic [OPC_W-1:0] ins_d;
    logic             halted_d, stk_err_d;
    logic             push, pop;
    logic [PC_W-1:0]  stk_top;
    logic             stk_full, stk_empty;
    logic [OPC_W-1:0] fetch_op;
    logic [PC_W-1:0]  fetch_opr;

    assign mem_addr  = pc;
    assign fetch_op  = mem_data[OPC_LSB +: OPC_W];
    assign fetch_opr = mem_data[OPR_LSB +: PC_W];

    ue14500_ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (iss_pc + PC_W'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next-state: halt freezes everything; otherwise jmp > rtn > flag_f > issue.
    // Every non-issue path emits a NOP0 bubble and leaves iss_pc alone.
    always_comb begin
        pc_d      = pc;
        iss_pc_d  = iss_pc;
        ins_d     = OP_NOP0;
        io_sel_d  = '0;
        halted_d  = halted;
        stk_err_d = stk_err;
        push      = 1'b0;
        pop       = 1'b0;
        if (halted) begin
            // frozen until reset
        end else if (jmp_flag) begin
            pc_d = io_sel;
            if (stk_full) stk_err_d = 1'b1;
            else          push      = 1'b1;
        end else if (rtn_flag) begin
            if (stk_empty) begin
                pc_d      = '0;
                stk_err_d = 1'b1;
            end else begin
                pc_d = stk_top;
                pop  = 1'b1;
            end
        end else if (flag_f && HALT_ON_F) begin
            halted_d = 1'b1;
        end else if (run) begin
            ins_d    = fetch_op;
            io_sel_d = fetch_opr;
            iss_pc_d = pc;
            pc_d     = pc + PC_W'(1);
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            iss_pc  <= '0;
            ins_out <= OP_NOP0;
            io_sel  <= '0;
            halted  <= 1'b0;
            stk_err <= 1'b0;
        end else begin
            pc      <= pc_d;
            iss_pc  <= iss_pc_d;
            ins_out <= ins_d;
            io_sel  <= io_sel_d;
            halted  <= halted_d;
            stk_err <= stk_err_d;
        end
    end

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Bench for ue14500_sequencer: directed program sequences followed by a
// randomized run, all compared against a queue-based reference model.
module tb_ue14500_sequencer;
    import ue14500_pkg::*;

    localparam int PC_W      = 8;
    localparam int DEPTH     = 4;
    localparam bit HALT_ON_F = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              run = 1'b0;
    logic [PC_W-1:0]   mem_addr;
    logic [PC_W+3:0]   mem_data;
    logic [3:0]        ins_out;
    logic [PC_W-1:0]   io_sel;
    logic              jmp_flag = 1'b0;
    logic              rtn_flag = 1'b0;
    logic              flag_f = 1'b0;
    logic              halted;
    logic              stk_err;

    logic [PC_W+3:0]   rom [256];
    assign mem_data = rom[mem_addr];

    ue14500_sequencer #(
        .PC_W      (PC_W),
        .DEPTH     (DEPTH),
        .HALT_ON_F (HALT_ON_F)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ins_out  (ins_out),
        .io_sel   (io_sel),
        .jmp_flag (jmp_flag),
        .rtn_flag (rtn_flag),
        .flag_f   (flag_f),
        .halted   (halted),
        .stk_err  (stk_err)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_pc, m_iss, m_io;
    logic [3:0] m_ins;
    logic       m_halt, m_err;
    logic [7:0] stk [$];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        m_pc = 0; m_iss = 0; m_io = 0; m_ins = 0;
        m_halt = 0; m_err = 0;
        stk.delete();
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        if (m_halt) begin
            m_ins = 0; m_io = 0;
        end else if (jmp_flag) begin
            if (stk.size() == DEPTH) m_err = 1;
            else stk.push_back(m_iss + 8'd1);
            m_pc = m_io; m_ins = 0; m_io = 0;
        end else if (rtn_flag) begin
            if (stk.size() == 0) begin m_pc = 0; m_err = 1; end
            else m_pc = stk.pop_back();
            m_ins = 0; m_io = 0;
        end else if (flag_f && HALT_ON_F) begin
            m_halt = 1; m_ins = 0; m_io = 0;
        end else if (run) begin
            m_ins = rom[m_pc][11:8];
            m_io  = rom[m_pc][7:0];
            m_iss = m_pc;
            m_pc  = m_pc + 8'd1;
        end else begin
            m_ins = 0; m_io = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(m_pc));
        chk({tag, " ins_out"},  32'(ins_out),  32'(m_ins));
        chk({tag, " io_sel"},   32'(io_sel),   32'(m_io));
        chk({tag, " halted"},   32'(halted),   32'(m_halt));
        chk({tag, " stk_err"},  32'(stk_err),  32'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    // Play the ICU: decode the expected ins_out into flags, optionally
    // adding random flag noise to exercise priority.
    task automatic set_in(input logic run_v, input bit noise);
        run      = run_v;
        jmp_flag = (m_ins == OP_JMP);
        rtn_flag = (m_ins == OP_RTN);
        flag_f   = (m_ins == OP_NOPF);
        if (noise && $urandom_range(0, 7) == 0) begin
            jmp_flag = 1'($urandom_range(0, 1));
            rtn_flag = 1'($urandom_range(0, 1));
            flag_f   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic cyc(input logic run_v, input string tag);
        set_in(run_v, 1'b0);
        step(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; run = 0; jmp_flag = 0; rtn_flag = 0; flag_f = 0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic rom_clear();
        for (int a = 0; a < 256; a++) rom[a] = '0;
    endtask

    function automatic logic [11:0] w(input opcode_t op, input logic [7:0] opr);
        return {op, opr};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int halt_cnt;
        rom_clear();
        model_reset();

        // Linear fetch
        rom[0] = w(OP_LD, 8'h05); rom[1] = w(OP_ONE, 8'h00);
        rom[2] = w(OP_STO, 8'h02); rom[3] = w(OP_NOP0, 8'h00);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, "linear");
        chk("linear end addr", 32'(mem_addr), 32'h4);

        // JMP then RTN
        rom_clear();
        rom[0] = w(OP_LD, 8'h05); rom[1] = w(OP_ONE, 8'h00);
        rom[2] = w(OP_JMP, 8'h10); rom[3] = w(OP_STO, 8'h02);
        rom[8'h10] = w(OP_RTN, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, "pre_jmp");
        cyc(1'b1, "jmp_bubble");
        cyc(1'b1, "jmp_target");
        cyc(1'b1, "rtn_bubble");
        cyc(1'b1, "rtn_resume");
        chk("rtn ins STO", 32'(ins_out), 32'(OP_STO));
        chk("rtn addr", 32'(mem_addr), 32'h4);
        chk("rtn stk_err", 32'(stk_err), 32'h0);

        // Stack limits: 5 nested jumps, 5 returns
        rom_clear();
        rom[8'h00] = w(OP_JMP, 8'h20); rom[8'h20] = w(OP_JMP, 8'h30);
        rom[8'h30] = w(OP_JMP, 8'h40); rom[8'h40] = w(OP_JMP, 8'h50);
        rom[8'h50] = w(OP_JMP, 8'h60); rom[8'h60] = w(OP_RTN, 8'h00);
        rom[8'h41] = w(OP_RTN, 8'h00); rom[8'h31] = w(OP_RTN, 8'h00);
        rom[8'h21] = w(OP_RTN, 8'h00); rom[8'h01] = w(OP_RTN, 8'h00);
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, "nest_jmp");
        chk("overflow err", 32'(stk_err), 32'h1);
        chk("overflow taken", 32'(mem_addr), 32'h60);
        for (int i = 0; i < 10; i++) cyc(1'b1, "nest_rtn");
        chk("underflow pc", 32'(mem_addr), 32'h0);
        chk("underflow err", 32'(stk_err), 32'h1);

        // Stall and wrap
        rom_clear();
        rom[8'h00] = w(OP_JMP, 8'hFE); rom[8'hFE] = w(OP_LD, 8'h07);
        rom[8'hFF] = w(OP_OR, 8'h03);
        do_reset();
        cyc(1'b1, "wrap_jmp");
        cyc(1'b1, "wrap_bubble");
        cyc(1'b1, "wrap_run1");
        cyc(1'b0, "wrap_stall1");
        cyc(1'b0, "wrap_stall2");
        chk("stall holds", 32'(mem_addr), 32'hFF);
        cyc(1'b1, "wrap_resume");
        chk("wrap to 0", 32'(mem_addr), 32'h00);
        cyc(1'b1, "wrap_after");

        // Halt, frozen, flags ignored, async reset
        rom_clear();
        rom[0] = w(OP_LD, 8'h01); rom[1] = w(OP_NOPF, 8'h00);
        rom[2] = w(OP_ONE, 8'h00); rom[5] = w(OP_XOR, 8'h09);
        do_reset();
        cyc(1'b1, "halt_pre");
        cyc(1'b1, "halt_nopf");
        cyc(1'b1, "halt_edge");
        chk("halted set", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) cyc(1'b1, "halt_frozen");
        run = 1; jmp_flag = 1; rtn_flag = 0; flag_f = 0;
        step("halt_jmp_ignored");
        jmp_flag = 0;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async pc", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Randomized run
        for (int a = 0; a < 256; a++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == OP_NOPF && $urandom_range(0, 3) != 0) op = OP_LD;
            rom[a] = {op, 8'($urandom_range(0, 255))};
        end
        do_reset();
        halt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 9) != 0), 1'b1);
            step("random");
            if (m_halt) halt_cnt++;
            if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_cnt = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ue14500_sequencer.md
Name: ue14500_sequencer

Overview:
- Instruction-stream source for the ue14500 1-bit ICU: program counter, program-ROM address generation, JMP/RTN handling and a return-address stack.
- Drives the 4-bit opcode and the I/O-select operand that the ICU consumes.
- Reacts to the ICU's JMP/RTN/F flag outputs.
- Sits between the external program ROM (asynchronous read) and the ICU core.

Parameters:
PC_W, 8, program counter, ROM address and operand width
DEPTH, 4, return-stack entries (power of 2, >=2)
HALT_ON_F, 1, 1 = NOPF with flag_f halts the sequencer

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
run  in  1  1 = fetch/issue; 0 = stall (NOP0 issued)
mem_addr  out  PC_W  ROM address; equals pc register
mem_data  in  4+PC_W  ROM word, async read; [PC_W+3:PC_W] opcode, [PC_W-1:0] operand
ins_out  out  4  opcode presented to ICU (registered)
io_sel  out  PC_W  operand of ins_out (registered); I/O mux select / jump target
jmp_flag  in  1  ICU decode of JMP, valid in the cycle ins_out=JMP
rtn_flag  in  1  ICU decode of RTN, same timing
flag_f  in  1  ICU decode of NOPF, same timing
halted  out  1  sticky halt status
stk_err  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (async, rst_n=0): pc=0, ins_out=0000 (NOP0), io_sel=0, iss_pc=0, sp=0, halted=0, stk_err=0. Stack contents are don't-care.
- The ICU consumes ins_out/io_sel at each rising edge. Flags describe the instruction currently on ins_out. All flag actions take effect at that same edge, regardless of run.
- Normal issue (run=1, !halted, no flag): ins_out<=opcode, io_sel<=operand, iss_pc<=pc, pc<=pc+1 (mod 2^PC_W, 0xFF wraps to 0x00). One instruction per cycle; fetch-to-issue latency is 1 edge.
- Stall (run=0): ins_out<=NOP0, io_sel<=0, pc held. On resume, issue continues at the held pc; no instruction is lost or duplicated.
- JMP (jmp_flag=1):
  - push iss_pc+1; pc<=io_sel.
  - ins_out<=NOP0 (one bubble), so the word at the old pc is never issued.
  - The target instruction is issued on the following edge if run=1.
- RTN (rtn_flag=1): pc<=stack top; sp-1; one NOP0 bubble.
- Priority: jmp_flag > rtn_flag > flag_f. Lower-priority flags in the same cycle are ignored.
- Overflow (push with sp=DEPTH): stack unchanged, stk_err<=1, jump still taken.
- Underflow (pop with sp=0): pc<=0, stk_err<=1, bubble issued.
- stk_err clears only on reset.
- Halt: flag_f=1 with HALT_ON_F=1 -> halted<=1 at that edge. From then on ins_out=NOP0, io_sel=0, pc frozen, flags ignored. Only reset clears it. With HALT_ON_F=0, NOPF is an ordinary no-op.
- Bubble cycles carry NOP0; iss_pc is not updated during a bubble.
- Reset mid-operation: immediate return to reset values; stack pointer cleared.
- No combinational path from the flag inputs to mem_addr or ins_out.

Decomposition:
- Package ue14500_pkg:
  - 4-bit opcode constants: NOP0=0000, LD=0001, ADD=0010, SUB=0011, ONE=0100, NAND=0101, OR=0110, XOR=0111, STO=1000, STOC=1001, IEN=1010, OEN=1011, JMP=1100, RTN=1101, SKZ=1110, NOPF=1111.
  - Instruction-word field position constants.
- Sub-module ue14500_ret_stack:
  - DEPTH x PC_W LIFO with push/pop/top/full/empty.
  - Async active-low reset of the pointer only.

Test Plan:
1. Linear fetch: ROM[0..3]={LD,5},{ONE,0},{STO,2},{NOP0,0}, run=1 after reset -> mem_addr 0,1,2,3,4; ins_out 1,4,8,0; io_sel 5,0,2,0 on consecutive cycles.
2. JMP: ROM[2]={JMP,0x10}, TB drives jmp_flag=1 while ins_out=1100 -> next ins_out=NOP0, then ROM[0x10]'s opcode; stack top=3, sp=1; ROM[3] never issued.
3. RTN: continue 2 with ROM[0x10]={RTN,0}, rtn_flag=1 -> NOP0 bubble, then ROM[3] issued, mem_addr=4, sp=0, stk_err=0.
4. Stack limits (DEPTH=4):
   - 5 nested JMPs -> stk_err=1 on the 5th, 5th jump still taken.
   - 4 RTNs return to the correct addresses.
   - 5th RTN -> pc=0, stk_err stays 1.
5. Stall/wrap: pc=0xFE, run toggles 1,0,0,1 -> ins_out NOP0 during stall, mem_addr holds; issue resumes at the held address; pc wraps 0xFF->0x00.
6. Halt/reset:
   - NOPF with flag_f=1 -> halted=1 next edge; ins_out=NOP0, mem_addr frozen for 10 cycles, later jmp_flag ignored.
   - rst_n=0 mid-cycle -> pc=0, ins_out=0, halted=0 immediately, without a clock edge.
